// File: rtl/rx_pkg.sv
// Shared definitions for the raw pixel packer: word tags, FSM states and
// the helpers that assemble the 16-bit output words.
package rx_pkg;

  localparam logic [1:0]  TAG_PIX       = 2'b00;
  localparam logic [1:0]  TAG_LINE      = 2'b01;
  localparam logic [1:0]  TAG_FRAME     = 2'b10;
  localparam logic [13:0] LINE_CNT_MAX  = 14'h3FFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DROP = 2'd2
  } state_t;

  function automatic logic [15:0] pix_word(input logic [9:0] pix);
    return {TAG_PIX, 4'b0000, pix};
  endfunction

  function automatic logic [15:0] line_word(input logic [13:0] cnt);
    return {TAG_LINE, cnt};
  endfunction

  function automatic logic [15:0] hdr_word(input logic trunc, input logic [7:0] fcnt);
    return {TAG_FRAME, trunc, 5'b00000, fcnt};
  endfunction

endpackage

// File: rtl/raw_pixel_packer_if.sv
// Output word stream (valid/ready) from the packer towards the host bridge.
interface raw_pixel_packer_if;
  logic [15:0] OUT_DATA;
  logic        OUT_VALID;
  logic        OUT_READY;

  modport master (output OUT_DATA, output OUT_VALID, input OUT_READY);
  modport slave  (input OUT_DATA, input OUT_VALID, output OUT_READY);
endinterface

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO. A push while full is accepted only when a
// pop happens in the same cycle. The head word reads as zero while empty.
module sync_fifo_fwft #(
  parameter int W  = 16,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop_ready,
  output logic [W-1:0]  out_data,
  output logic          out_valid,
  output logic [AW:0]   count
);

  localparam int          DEPTH    = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  // Pointer/occupancy update for this cycle's push and pop.
  always_comb begin
    do_pop   = (count_q != '0) & pop_ready;
    do_push  = push & ((count_q != FULL_CNT) | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers; reset empties the FIFO at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array, written without reset so it maps onto RAM.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_data  = out_valid ? mem[rd_ptr_q] : '0;
  assign count     = count_q;

endmodule

// File: rtl/raw_pixel_packer.sv
// Tags the raw pixel stream and H/V sync events into 16-bit words and
// queues them in a FWFT FIFO. The input cannot stall, so a full FIFO
// truncates the current frame instead of back-pressuring the source.
module raw_pixel_packer
  import rx_pkg::*;
#(
  parameter int D_WIDTH = 10,
  parameter int FIFO_AW = 6
) (
  input  logic                CLOCK,
  input  logic                RESET,
  input  logic [D_WIDTH-1:0]  PAR_INPUT,
  input  logic                RDAT_VALID,
  input  logic                H_SYNC,
  input  logic                V_SYNC,
  raw_pixel_packer_if.master  out_if,
  output logic                OVERFLOW,
  output logic [7:0]          FRAME_CNT
);

  localparam logic [FIFO_AW:0] FIFO_FULL = (FIFO_AW+1)'(1 << FIFO_AW);

  // Input sample stage
  logic               hs_q, hs_d, vs_q, vs_d;
  logic               pix_vld_q, pix_vld_d;
  logic [D_WIDTH-1:0] pix_q, pix_d;
  logic               hfall_q, hfall_d, vrise_q, vrise_d;

  // Framing state
  state_t             state_q, state_d;
  logic [7:0]         frame_cnt_q, frame_cnt_d;
  logic [13:0]        line_cnt_q, line_cnt_d;
  logic               trunc_q, trunc_d;
  logic               ovf_q, ovf_d;
  logic               pend_q, pend_d;

  // FIFO write side
  logic               wr_req, wr_ok, pop, fifo_valid;
  logic [15:0]        wr_data;
  logic [FIFO_AW:0]   fifo_count;
  logic               hdr_evt, defer;
  logic [7:0]         frame_inc;

  assign frame_inc = frame_cnt_q + 8'd1;

  // Edge detection against the previous sync levels; pixels only count inside H_SYNC.
  always_comb begin
    hs_d      = H_SYNC;
    vs_d      = V_SYNC;
    pix_vld_d = RDAT_VALID & H_SYNC;
    pix_d     = PAR_INPUT;
    hfall_d   = hs_q & ~H_SYNC;
    vrise_d   = ~vs_q & V_SYNC;
  end

  // Input sample registers: the one-cycle stage in front of the FIFO write.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      hs_q      <= 1'b0;
      vs_q      <= 1'b0;
      pix_vld_q <= 1'b0;
      pix_q     <= '0;
      hfall_q   <= 1'b0;
      vrise_q   <= 1'b0;
    end else begin
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      pix_vld_q <= pix_vld_d;
      pix_q     <= pix_d;
      hfall_q   <= hfall_d;
      vrise_q   <= vrise_d;
    end
  end

  // A write lands if there is room, or if the head is leaving this cycle.
  assign pop   = fifo_valid & out_if.OUT_READY;
  assign wr_ok = (fifo_count != FIFO_FULL) | pop;

  // Next-state, counters and the single FIFO write for this cycle.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    line_cnt_d  = line_cnt_q;
    trunc_d     = trunc_q;
    ovf_d       = ovf_q;
    pend_d      = 1'b0;
    wr_req      = 1'b0;
    wr_data     = '0;
    defer       = 1'b0;
    hdr_evt     = 1'b0;
    case (state_q)
      IDLE: begin
        if (vrise_q) begin
          wr_req      = 1'b1;
          wr_data     = hdr_word(1'b0, 8'd0);
          frame_cnt_d = 8'd0;
          line_cnt_d  = '0;
          if (wr_ok) begin
            state_d = RUN;
          end else begin
            state_d = DROP;
            ovf_d   = 1'b1;
            trunc_d = 1'b1;
          end
        end
      end
      RUN: begin
        // A line end that coincides with a frame start goes first; the header follows next cycle.
        defer   = hfall_q & vrise_q;
        hdr_evt = pend_q | (vrise_q & ~defer);
        if (hdr_evt) begin
          wr_req      = 1'b1;
          wr_data     = hdr_word(1'b0, frame_inc);
          frame_cnt_d = frame_inc;
          line_cnt_d  = '0;
        end else if (hfall_q) begin
          wr_req     = 1'b1;
          wr_data    = line_word(line_cnt_q);
          line_cnt_d = '0;
          pend_d     = defer;
        end else if (pix_vld_q) begin
          wr_req  = 1'b1;
          wr_data = pix_word(pix_q);
          if (line_cnt_q != LINE_CNT_MAX) begin
            line_cnt_d = line_cnt_q + 14'd1;
          end
        end
        if (wr_req && !wr_ok) begin
          state_d = DROP;
          ovf_d   = 1'b1;
          trunc_d = 1'b1;
        end
      end
      DROP: begin
        // Only a frame header can leave DROP; everything else is thrown away.
        hdr_evt = pend_q | vrise_q;
        if (hdr_evt) begin
          wr_req      = 1'b1;
          wr_data     = hdr_word(trunc_q, frame_inc);
          frame_cnt_d = frame_inc;
          line_cnt_d  = '0;
          if (wr_ok) begin
            trunc_d = 1'b0;
            state_d = RUN;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and framing counters.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      frame_cnt_q <= 8'd0;
      line_cnt_q  <= '0;
      trunc_q     <= 1'b0;
      ovf_q       <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      line_cnt_q  <= line_cnt_d;
      trunc_q     <= trunc_d;
      ovf_q       <= ovf_d;
      pend_q      <= pend_d;
    end
  end

  sync_fifo_fwft #(
    .W  (16),
    .AW (FIFO_AW)
  ) u_fifo (
    .clk       (CLOCK),
    .rst       (RESET),
    .push      (wr_req & wr_ok),
    .push_data (wr_data),
    .pop_ready (out_if.OUT_READY),
    .out_data  (out_if.OUT_DATA),
    .out_valid (fifo_valid),
    .count     (fifo_count)
  );

  assign out_if.OUT_VALID = fifo_valid;
  assign OVERFLOW         = ovf_q;
  assign FRAME_CNT        = frame_cnt_q;

endmodule

// File: doc/raw_pixel_packer.md
# raw_pixel_packer

Receive-side output stage downstream of the output register in the 48 MHz domain. It takes the 10-bit raw pixel stream plus H_SYNC/V_SYNC, tags pixels and frame/line events into 16-bit words, and buffers them in a FIFO. The FIFO drains through a valid/ready port to the host interface (USB FIFO bridge). Input cannot be stalled, so FIFO overflow is handled by truncating the current frame, never by back-pressuring the read controller.

## Interface
- D_WIDTH, 10, pixel width; fixed at 10 for the word formats below.
- FIFO_AW, 6, FIFO address width; depth = 2^FIFO_AW words.
- CLOCK  in  1  48 MHz system clock; the only clock.
- RESET  in  1  asynchronous, active-high reset.
- PAR_INPUT  in  D_WIDTH  pixel data, qualified by RDAT_VALID.
- RDAT_VALID  in  1  pixel strobe; honoured only while H_SYNC=1.
- H_SYNC  in  1  high for the active line; a falling edge ends the line.
- V_SYNC  in  1  a rising edge marks frame start.
- OUT_DATA  out  16  FIFO head word.
- OUT_VALID  out  1  FIFO not empty.
- OUT_READY  in  1  consumer accepts; a pop occurs when OUT_VALID & OUT_READY.
- OVERFLOW  out  1  sticky; set on the first dropped word; cleared by RESET only.
- FRAME_CNT  out  8  sequence number of the last frame header generated.

## Operation
- Word formats, with bits [15:14] as the tag:
  - Pixel: {2'b00, 4'b0000, pix[9:0]}.
  - Line end: {2'b01, line_pix_cnt[13:0]}. The count saturates at 16383.
  - Frame header: {2'b10, trunc, 5'b0, frame_cnt[7:0]}. trunc=1 if the previous frame was truncated.
  - Tag 2'b11 is reserved and never emitted.
- Edge detection: H_SYNC and V_SYNC are registered once. An edge is the current value versus the registered value.
- State machine:
  - IDLE (reset state): all inputs are discarded. On a V_SYNC rise, write a header with frame_cnt=0 and trunc=0, then go to RUN.
  - RUN:
    - A valid pixel writes a pixel word and increments line_pix_cnt.
    - An H_SYNC fall writes a line-end word and clears line_pix_cnt.
    - A V_SYNC rise increments frame_cnt (mod 256), writes a header with trunc=0, and clears line_pix_cnt.
  - DROP:
    - Entered on any rejected write. Sets OVERFLOW and the internal trunc_flag.
    - Pixel and line-end words are discarded.
    - On a V_SYNC rise, increment frame_cnt and write a header with trunc=1.
    - If that header is accepted, clear trunc_flag and go to RUN. If the header is itself rejected, stay in DROP with trunc still pending.
- FIFO write acceptance: a write is accepted if count < depth, or if a pop occurs in the same cycle.
- Collisions: a header and a line-end in the same cycle are written as line-end first, then the header next cycle via a one-deep pending register. Pixels cannot coincide with either, because they require H_SYNC=1 and no edge.
- A pixel with RDAT_VALID=1 but H_SYNC=0 is ignored and not counted.
- FRAME_CNT follows frame_cnt and updates on header generation, whether or not the header is accepted.

## Timing
- Reset values: OUT_VALID=0, OUT_DATA=16'h0000, OVERFLOW=0, FRAME_CNT=0. The FIFO is emptied, the state is IDLE, and pending/trunc are cleared.
- Reset mid-operation: contents are flushed immediately (asynchronous). The next frame starts from IDLE.
- Input-to-output latency:
  - A pixel sampled at cycle n is written at the n+1 edge. With the FIFO empty, OUT_VALID=1 and OUT_DATA are valid during cycle n+2.
  - An edge event follows the same timing, counted from the cycle the edge appears on the input.
- FIFO behaviour:
  - First-word-fall-through.
  - OUT_DATA is stable while OUT_VALID=1 and OUT_READY=0.
  - Sustained throughput is one word per cycle.
- Counter widths: line_pix_cnt is 14-bit saturating; frame_cnt is 8-bit wrapping (255 → 0).

## Structure
- Shared package rx_pkg holds:
  - tag constants TAG_PIX=2'b00, TAG_LINE=2'b01, TAG_FRAME=2'b10;
  - the state enum {IDLE, RUN, DROP};
  - the word-assembly functions.
- One sub-module, sync_fifo_fwft: parameterised width/AW, count output, async active-high reset, concurrent push/pop when full.

## Test plan
- Reset, then V_SYNC rise, then 3 pixels (0x3FF, 0x001, 0x155), then H_SYNC fall, with OUT_READY=1. Required output, in order: 0x8000, 0x03FF, 0x0001, 0x0155, 0x4003, each appearing 2 cycles after its input.
- Pixels before the first V_SYNC rise: no output words; OUT_VALID stays 0.
- OUT_READY=0 with FIFO_AW=2 and a 10-pixel line:
  - The header plus 3 pixels are accepted; the 4th pixel sets OVERFLOW; the line-end is dropped.
  - After draining, the next V_SYNC produces 0xA001.
  - A following full frame passes with header 0x8002.
- 257 frame starts: the header sequence runs 0x8000 … 0x80FF, 0x8000; FRAME_CNT wraps to 0.
- An H_SYNC fall and a V_SYNC rise in the same cycle: the line-end word is emitted first, then the header one cycle later.
- RESET asserted with 5 words queued: OUT_VALID drops to 0 asynchronously, and no stale words appear after reset release.
